// File: rtl/ram_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined byte-lane RAM.
package ram_pkg;

  localparam int unsigned LANE_WIDTH = 8;

  // Ceiling log2; clog2(1) == 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned p = 1; p < value; p = p << 1) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/ram_rsp_fifo.sv
// Small response FIFO with wrapping pointers; any depth >= 1, no combinational bypass.
module ram_rsp_fifo
  import ram_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 3
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        push,
  input  logic [WIDTH-1:0]            push_data,
  input  logic                        pop,
  output logic [WIDTH-1:0]            pop_data,
  output logic                        empty,
  output logic [clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PW = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1;
  localparam int unsigned CW = clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_pop;

  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  // Next pointer/occupancy; a pop while empty is ignored
  always_comb begin
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
    end
    case ({push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state, cleared asynchronously
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are don't-care until pushed
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/ram_pipelined.sv
// Single-port byte-lane RAM with valid/ready requests, credit-limited read
// pipeline and an in-order response queue.
module ram_pipelined
  import ram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned LANES        = 4,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_write,
  input  logic [ADDR_WIDTH-1:0]       address,
  input  logic [LANE_WIDTH*LANES-1:0] data_in,
  input  logic [LANES-1:0]            write_mask,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [LANE_WIDTH*LANES-1:0] data_out,
  output logic [7:0]                  debug
);

  localparam int unsigned DW     = LANE_WIDTH * LANES;
  localparam int unsigned OFFS   = clog2(LANES);
  localparam int unsigned WW     = ADDR_WIDTH - OFFS;
  localparam int unsigned DEPTH  = 1 << WW;
  localparam int unsigned QDEPTH = READ_LATENCY + 2;
  localparam int unsigned OW     = clog2(QDEPTH + 1);

  logic [DW-1:0] mem_q [DEPTH];
  logic [WW-1:0] word_idx;
  logic          accept, wr_acc, rd_acc, rsp_hs;
  logic [OW-1:0] out_q, out_d;
  logic [7:0]    debug_q, debug_d;
  logic          rd_vld0_q, rd_vld0_d;
  logic [DW-1:0] rd_data0_q;
  logic          push;
  logic [DW-1:0] push_data;
  logic          fifo_empty;
  logic [DW-1:0] fifo_head;
  logic [OW-1:0] unused_fifo_count;

  // Credits are a function of registered state only
  assign req_ready = (out_q < OW'(QDEPTH));
  assign rsp_valid = !fifo_empty;
  assign data_out  = fifo_empty ? '0 : fifo_head;
  assign debug     = debug_q;

  if (OFFS > 0) begin : g_offs
    logic unused_offs;
    assign unused_offs = ^address[OFFS-1:0];
  end

  // Request decode, credit and debug next-state
  always_comb begin
    word_idx  = address[ADDR_WIDTH-1:OFFS];
    accept    = req_valid && req_ready;
    wr_acc    = accept && req_write;
    rd_acc    = accept && !req_write;
    rsp_hs    = rsp_valid && rsp_ready;
    rd_vld0_d = rd_acc;
    debug_d   = wr_acc ? 8'(write_mask) : debug_q;
    case ({rd_acc, rsp_hs})
      2'b10:   out_d = out_q + OW'(1);
      2'b01:   out_d = out_q - OW'(1);
      default: out_d = out_q;
    endcase
  end

  // Control registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q     <= '0;
      debug_q   <= '0;
      rd_vld0_q <= 1'b0;
    end else begin
      out_q     <= out_d;
      debug_q   <= debug_d;
      rd_vld0_q <= rd_vld0_d;
    end
  end

  // Byte-lane array write; mask bit low enables the lane
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (!write_mask[i]) begin
          mem_q[word_idx][i*LANE_WIDTH +: LANE_WIDTH] <= data_in[i*LANE_WIDTH +: LANE_WIDTH];
        end
      end
    end
  end

  // Synchronous array read
  always_ff @(posedge clk) begin
    if (rd_acc) begin
      rd_data0_q <= mem_q[word_idx];
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic          rd_vld1_q, rd_vld1_d;
    logic [DW-1:0] rd_data1_q;

    // Output register stage after the array
    always_comb begin
      rd_vld1_d = rd_vld0_q;
      push      = rd_vld1_q;
      push_data = rd_data1_q;
    end

    // Second-stage valid
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) rd_vld1_q <= 1'b0;
      else          rd_vld1_q <= rd_vld1_d;
    end

    // Second-stage data
    always_ff @(posedge clk) begin
      rd_data1_q <= rd_data0_q;
    end
  end else begin : g_lat1
    // Array output feeds the queue directly
    always_comb begin
      push      = rd_vld0_q;
      push_data = rd_data0_q;
    end
  end

  ram_rsp_fifo #(
    .WIDTH (DW),
    .DEPTH (QDEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_data),
    .pop       (rsp_hs),
    .pop_data  (fifo_head),
    .empty     (fifo_empty),
    .count     (unused_fifo_count)
  );

endmodule

// File: tb/tb_ram_pipelined.sv
// Bench for ram_pipelined: one instance per read latency (1 and 2), exercised
// in turn against a byte-addressed memory model and an expected-response queue.
module tb_ram_pipelined;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       req_valid  [2];
  logic       req_ready  [2];
  logic       req_write  [2];
  logic [9:0] address    [2];
  logic [31:0] data_in   [2];
  logic [3:0] write_mask [2];
  logic       rsp_valid  [2];
  logic       rsp_ready  [2];
  logic [31:0] data_out  [2];
  logic [7:0] debug      [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    ram_pipelined #(
      .ADDR_WIDTH   (10),
      .LANES        (4),
      .READ_LATENCY (g + 1)
    ) u_dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_write  (req_write[g]),
      .address    (address[g]),
      .data_in    (data_in[g]),
      .write_mask (write_mask[g]),
      .rsp_valid  (rsp_valid[g]),
      .rsp_ready  (rsp_ready[g]),
      .data_out   (data_out[g]),
      .debug      (debug[g])
    );
  end

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Reference model: byte-addressed memory, queue of expected read words with
  // the edge each read was accepted on, and the last accepted write mask.
  logic [7:0]  mem_m [1024];
  logic [31:0] expq  [$];
  int unsigned edgeq [$];
  int unsigned cyc = 0;
  logic [7:0]  dbg_m;
  int unsigned dut_rsp_cnt = 0;

  function automatic int unsigned lat(input int k);
    return k + 1;
  endfunction

  function automatic int unsigned qd(input int k);
    return k + 3;
  endfunction

  function automatic logic [31:0] word_at(input logic [9:0] a);
    logic [9:0] b;
    b = {a[9:2], 2'b00};
    return {mem_m[b + 10'd3], mem_m[b + 10'd2], mem_m[b + 10'd1], mem_m[b]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs against the model, then advance model and clock.
  task automatic step(input int k, output bit accepted);
    bit exp_ready;
    bit exp_valid;
    bit hs;
    exp_ready = (expq.size() < qd(k));
    exp_valid = 1'b0;
    if (expq.size() > 0) exp_valid = (cyc >= edgeq[0] + lat(k));
    chk("req_ready", {63'd0, req_ready[k]}, {63'd0, exp_ready});
    chk("rsp_valid", {63'd0, rsp_valid[k]}, {63'd0, exp_valid});
    if (exp_valid) chk("data_out", {32'd0, data_out[k]}, {32'd0, expq[0]});
    chk("debug", {56'd0, debug[k]}, {56'd0, dbg_m});
    if (rsp_valid[k] === 1'b1 && rsp_ready[k]) dut_rsp_cnt++;
    accepted = req_valid[k] && exp_ready;
    hs = exp_valid && rsp_ready[k];
    if (hs) begin
      void'(expq.pop_front());
      void'(edgeq.pop_front());
    end
    if (accepted) begin
      if (req_write[k]) begin
        for (int i = 0; i < 4; i++) begin
          if (!write_mask[k][i]) mem_m[{address[k][9:2], 2'(i)}] = data_in[k][8*i +: 8];
        end
        dbg_m = {4'd0, write_mask[k]};
      end else begin
        expq.push_back(word_at(address[k]));
        edgeq.push_back(cyc + 1);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic issue(input int k, input logic w, input logic [9:0] a,
                       input logic [31:0] d, input logic [3:0] m, input logic rr);
    bit got;
    got = 1'b0;
    req_valid[k]  = 1'b1;
    req_write[k]  = w;
    address[k]    = a;
    data_in[k]    = d;
    write_mask[k] = m;
    rsp_ready[k]  = rr;
    for (int n = 0; n < 20 && !got; n++) step(k, got);
    if (!got) chk("issue_timeout", 64'd0, 64'd1);
    req_valid[k] = 1'b0;
  endtask

  task automatic idle(input int k, input int n, input logic rr);
    bit dummy;
    req_valid[k] = 1'b0;
    rsp_ready[k] = rr;
    for (int i = 0; i < n; i++) step(k, dummy);
  endtask

  task automatic drain(input int k);
    bit dummy;
    req_valid[k] = 1'b0;
    rsp_ready[k] = 1'b1;
    for (int n = 0; n < 40 && expq.size() > 0; n++) step(k, dummy);
    if (expq.size() != 0) chk("drain_timeout", 64'(expq.size()), 64'd0);
    step(k, dummy);
    chk("drain_idle", {63'd0, rsp_valid[k]}, 64'd0);
  endtask

  task automatic reset_all(input int k);
    reset_n = 1'b0;
    for (int j = 0; j < 2; j++) begin
      req_valid[j]  = 1'b0;
      req_write[j]  = 1'b0;
      address[j]    = '0;
      data_in[j]    = '0;
      write_mask[j] = '1;
      rsp_ready[j]  = 1'b0;
    end
    expq.delete();
    edgeq.delete();
    dbg_m = 8'h00;
    #1;
    chk("rst_rsp_valid", {63'd0, rsp_valid[k]}, 64'd0);
    chk("rst_data_out", {32'd0, data_out[k]}, 64'd0);
    chk("rst_req_ready", {63'd0, req_ready[k]}, 64'd1);
    chk("rst_debug", {56'd0, debug[k]}, 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    cyc += 2;
    reset_n = 1'b1;
  endtask

  task automatic run(input int k);
    bit dummy;
    int unsigned start;
    reset_all(k);

    // Fill every word so reads are fully defined
    for (int w = 0; w < 256; w++) issue(k, 1'b1, 10'(w * 4), $urandom, 4'b0000, 1'b1);

    // Full write then read
    issue(k, 1'b1, 10'h010, 32'hDEADBEEF, 4'b0000, 1'b0);
    issue(k, 1'b0, 10'h010, 32'h0, 4'hF, 1'b0);
    idle(k, int'(lat(k)), 1'b0);
    chk("t1_valid", {63'd0, rsp_valid[k]}, 64'd1);
    chk("t1_data", {32'd0, data_out[k]}, 64'hDEADBEEF);
    chk("t1_debug", {56'd0, debug[k]}, 64'h00);
    drain(k);

    // Masked write
    issue(k, 1'b1, 10'h010, 32'h11223344, 4'b1010, 1'b0);
    issue(k, 1'b0, 10'h010, 32'h0, 4'hF, 1'b0);
    idle(k, int'(lat(k)), 1'b0);
    chk("t2_data", {32'd0, data_out[k]}, 64'hDE22BE44);
    chk("t2_debug", {56'd0, debug[k]}, 64'h0A);
    drain(k);

    // Read immediately after write, unaligned address
    issue(k, 1'b1, 10'h3FC, 32'h0000CAFE, 4'b0000, 1'b0);
    issue(k, 1'b0, 10'h3FD, 32'h0, 4'hF, 1'b0);
    idle(k, int'(lat(k)), 1'b0);
    chk("t3_data", {32'd0, data_out[k]}, 64'h0000CAFE);
    drain(k);

    // Backpressure: credits run out after QDEPTH reads
    for (int j = 0; j < int'(qd(k)); j++) issue(k, 1'b0, 10'(j * 4), 32'h0, 4'hF, 1'b0);
    chk("bp_ready_low", {63'd0, req_ready[k]}, 64'd0);
    req_valid[k] = 1'b1;
    req_write[k] = 1'b0;
    address[k]   = 10'(qd(k) * 4);
    for (int j = 0; j < 3; j++) step(k, dummy);
    chk("bp_still_low", {63'd0, req_ready[k]}, 64'd0);
    req_valid[k] = 1'b0;
    start = dut_rsp_cnt;
    drain(k);
    chk("bp_rsp_count", 64'(dut_rsp_cnt - start), 64'(qd(k)));
    issue(k, 1'b0, 10'(qd(k) * 4), 32'h0, 4'hF, 1'b1);
    drain(k);

    // Streaming reads with the consumer always ready
    start = dut_rsp_cnt;
    for (int j = 0; j < 64; j++) issue(k, 1'b0, 10'($urandom), 32'h0, 4'hF, 1'b1);
    drain(k);
    chk("stream_count", 64'(dut_rsp_cnt - start), 64'd64);

    // Random mixed traffic
    for (int j = 0; j < 300; j++) begin
      req_valid[k]  = ($urandom_range(0, 3) != 0);
      req_write[k]  = ($urandom_range(0, 2) == 0);
      address[k]    = 10'($urandom);
      data_in[k]    = $urandom;
      write_mask[k] = 4'($urandom);
      rsp_ready[k]  = ($urandom_range(0, 3) != 0);
      step(k, dummy);
    end
    drain(k);

    // Reset with two reads in flight
    issue(k, 1'b0, 10'h010, 32'h0, 4'hF, 1'b0);
    issue(k, 1'b0, 10'h014, 32'h0, 4'hF, 1'b0);
    reset_all(k);
    idle(k, 6, 1'b1);
    chk("post_rst_ready", {63'd0, req_ready[k]}, 64'd1);
    chk("post_rst_valid", {63'd0, rsp_valid[k]}, 64'd0);
    // Memory survives reset
    issue(k, 1'b0, 10'h3FC, 32'h0, 4'hF, 1'b1);
    drain(k);
  endtask

  initial begin
    reset_n = 1'b0;
    for (int j = 0; j < 2; j++) begin
      req_valid[j]  = 1'b0;
      req_write[j]  = 1'b0;
      address[j]    = '0;
      data_in[j]    = '0;
      write_mask[j] = '1;
      rsp_ready[j]  = 1'b0;
    end
    run(0);
    run(1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
